// File: rtl/rs_frame_pkg.sv
// rs_frame_pkg: RS(68,60) framing constants and types shared by the converter, packer and decoder wrapper.
package rs_frame_pkg;
  localparam int RS_N = 68;
  localparam int RS_K = 60;
  localparam int RS_SYMBOL_WIDTH = 8;
  localparam int RS_TOTAL_BITS = RS_N * RS_SYMBOL_WIDTH;
  typedef logic [RS_SYMBOL_WIDTH-1:0] symbol_t;
  typedef enum logic {IDLE, COLLECT} packer_state_t;
endpackage

// File: rtl/rs_symbol_packer_if.sv
// rs_symbol_packer_if: serial bit input and framed symbol output of the RS symbol packer.
interface rs_symbol_packer_if
  import rs_frame_pkg::*;
#(
  parameter int N = RS_N,
  parameter int SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
  parameter int CW_COUNT_WIDTH = 16
);
  logic bit_in;
  logic bit_in_valid;
  logic [SYMBOL_WIDTH-1:0] symbol_out;
  logic symbol_out_valid;
  logic symbol_sop;
  logic symbol_eop;
  logic symbol_is_parity;
  logic [$clog2(N)-1:0] symbol_index;
  logic frame_error;
  logic [CW_COUNT_WIDTH-1:0] codeword_count;
  modport master (
    output bit_in, bit_in_valid,
    input symbol_out, symbol_out_valid, symbol_sop, symbol_eop, symbol_is_parity,
    input symbol_index, frame_error, codeword_count
  );
  modport slave (
    input bit_in, bit_in_valid,
    output symbol_out, symbol_out_valid, symbol_sop, symbol_eop, symbol_is_parity,
    output symbol_index, frame_error, codeword_count
  );
endinterface

// File: rtl/rs_symbol_packer.sv
// rs_symbol_packer: packs an LSB-first serial bit stream into RS symbols framed as N-symbol codewords,
// discarding any partial codeword that stalls for GAP_TIMEOUT idle cycles.
module rs_symbol_packer
  import rs_frame_pkg::*;
#(
  parameter int N = RS_N,
  parameter int K = RS_K,
  parameter int SYMBOL_WIDTH = RS_SYMBOL_WIDTH,
  parameter int GAP_TIMEOUT = 16,
  parameter int CW_COUNT_WIDTH = 16
) (
  input logic clk,
  input logic rstn,
  rs_symbol_packer_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int BW = $clog2(SYMBOL_WIDTH);
  packer_state_t state;
  logic [BW-1:0] bit_cnt;
  logic [IW-1:0] sym_cnt;
  logic [7:0] gap_cnt;
  logic [SYMBOL_WIDTH-1:0] acc;
  logic [SYMBOL_WIDTH-1:0] shifted;
  logic sym_done;
  logic cw_done;
  // Shifting in at the MSB places the k-th accepted bit at position k once the symbol is full.
  assign shifted = {bus.bit_in, acc[SYMBOL_WIDTH-1:1]};
  assign sym_done = bit_cnt == BW'(SYMBOL_WIDTH - 1);
  assign cw_done = sym_cnt == IW'(N - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      bit_cnt <= '0;
      sym_cnt <= '0;
      gap_cnt <= '0;
      acc <= '0;
      bus.symbol_out <= '0;
      bus.symbol_out_valid <= 1'b0;
      bus.symbol_sop <= 1'b0;
      bus.symbol_eop <= 1'b0;
      bus.symbol_is_parity <= 1'b0;
      bus.symbol_index <= '0;
      bus.frame_error <= 1'b0;
      bus.codeword_count <= '0;
    end else begin
      bus.symbol_out_valid <= 1'b0;
      bus.symbol_sop <= 1'b0;
      bus.symbol_eop <= 1'b0;
      bus.symbol_is_parity <= 1'b0;
      bus.symbol_index <= '0;
      bus.frame_error <= 1'b0;
      if (bus.bit_in_valid) begin
        gap_cnt <= '0;
        acc <= shifted;
        bit_cnt <= sym_done ? '0 : bit_cnt + 1'b1;
        state <= (sym_done && cw_done) ? IDLE : COLLECT;
        if (sym_done) begin
          bus.symbol_out <= shifted;
          bus.symbol_out_valid <= 1'b1;
          bus.symbol_sop <= sym_cnt == '0;
          bus.symbol_eop <= cw_done;
          bus.symbol_is_parity <= sym_cnt >= IW'(K);
          bus.symbol_index <= sym_cnt;
          sym_cnt <= cw_done ? '0 : sym_cnt + 1'b1;
          if (cw_done) bus.codeword_count <= bus.codeword_count + 1'b1;
        end
      end else if (state == COLLECT) begin
        if (gap_cnt == 8'(GAP_TIMEOUT - 1)) begin
          bus.frame_error <= 1'b1;
          state <= IDLE;
          gap_cnt <= '0;
          bit_cnt <= '0;
          sym_cnt <= '0;
          acc <= '0;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_symbol_packer.sv
// tb_rs_symbol_packer: randomized stimulus against a symbol-list reference model of the RS symbol packer.
module tb_rs_symbol_packer;
  import rs_frame_pkg::*;
  typedef struct packed {
    logic [7:0] s;
    logic sop;
    logic eop;
    logic par;
    logic [6:0] idx;
    logic [15:0] cnt;
  } rec_t;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ferr = 0;
  int cw = 0;
  logic [7:0] data[$];
  rec_t got[$];
  rec_t exp[$];
  int gcyc[$];
  rs_symbol_packer_if bus();
  rs_symbol_packer dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.symbol_out_valid) begin
        got.push_back({bus.symbol_out, bus.symbol_sop, bus.symbol_eop, bus.symbol_is_parity,
                       bus.symbol_index, bus.codeword_count});
        gcyc.push_back(cyc);
      end
      if (bus.frame_error) ferr++;
      checks++;
      if (bus.frame_error && bus.symbol_out_valid) begin
        errors++;
        $display("FAIL overlap frame_error=1 with symbol_out_valid=1 at cycle %0d", cyc);
      end
      if (!bus.symbol_out_valid) begin
        checks++;
        if ({bus.symbol_sop, bus.symbol_eop, bus.symbol_is_parity, bus.symbol_index} !== 10'd0) begin
          errors++;
          $display("FAIL idle_strobes got sop/eop/par/idx %b want 0 at cycle %0d",
                   {bus.symbol_sop, bus.symbol_eop, bus.symbol_is_parity, bus.symbol_index}, cyc);
        end
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  task automatic drive(input logic b, input logic v);
    bus.bit_in = b;
    bus.bit_in_valid = v;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'($urandom), 1'b0);
  endtask
  task automatic send(input int first, input int last, input bit gaps);
    for (int i = first; i < last; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 15));
      drive(data[i / 8][i % 8], 1'b1);
    end
  endtask
  task automatic fill_random(input int n);
    data.delete();
    repeat (n) data.push_back(8'($urandom));
  endtask
  task automatic start();
    got.delete();
    gcyc.delete();
    ferr = 0;
  endtask
  // Reference: the j-th emitted symbol is the j-th byte of the stream at codeword position j mod N.
  task automatic make_exp(input int nsym);
    exp.delete();
    for (int j = 0; j < nsym; j++) begin
      int idx = j % RS_N;
      exp.push_back({data[j], idx == 0, idx == RS_N - 1, idx >= RS_K, 7'(idx), 16'(cw + (j + 1) / RS_N)});
    end
  endtask
  task automatic test_reset();
    #1 rstn = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_in_valid = 1'b0;
    #2;
    checks++;
    if ({bus.symbol_out, bus.symbol_out_valid, bus.frame_error, bus.codeword_count, bus.symbol_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {bus.symbol_out, bus.symbol_out_valid, bus.frame_error, bus.codeword_count, bus.symbol_index});
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(3);
    checks++;
    if ({bus.symbol_out_valid, bus.frame_error, bus.codeword_count} !== '0) begin
      errors++;
      $display("FAIL after_reset got %h want 0", {bus.symbol_out_valid, bus.frame_error, bus.codeword_count});
    end
  endtask
  task automatic test_full_codeword();
    start();
    data.delete();
    for (int i = 0; i < RS_N; i++) data.push_back(8'(i));
    make_exp(RS_N);
    send(0, RS_TOTAL_BITS, 0);
    idle(3);
    cw += 1;
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL full_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL full_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    for (int i = 1; i < gcyc.size(); i++) begin
      checks++;
      if (gcyc[i] - gcyc[i-1] !== 8) begin
        errors++;
        $display("FAIL full_spacing%0d got %0d want 8", i, gcyc[i] - gcyc[i-1]);
      end
    end
    checks++;
    if (bus.codeword_count !== 16'(cw)) begin
      errors++;
      $display("FAIL full_cw_count got %0d want %0d", bus.codeword_count, cw);
    end
  endtask
  task automatic test_back_to_back();
    start();
    fill_random(2 * RS_N);
    make_exp(2 * RS_N);
    send(0, 2 * RS_TOTAL_BITS, 0);
    idle(3);
    cw += 2;
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    for (int i = 1; i < gcyc.size(); i++) begin
      checks++;
      if (gcyc[i] - gcyc[i-1] !== 8) begin
        errors++;
        $display("FAIL b2b_spacing%0d got %0d want 8", i, gcyc[i] - gcyc[i-1]);
      end
    end
    checks++;
    if (bus.codeword_count !== 16'(cw)) begin
      errors++;
      $display("FAIL b2b_cw_count got %0d want %0d", bus.codeword_count, cw);
    end
  endtask
  task automatic test_gaps();
    start();
    fill_random(RS_N);
    make_exp(RS_N);
    send(0, RS_TOTAL_BITS, 1);
    idle(3);
    cw += 1;
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL gaps_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL gaps_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (ferr !== 0) begin
      errors++;
      $display("FAIL gaps_frame_error got %0d pulses want 0", ferr);
    end
  endtask
  task automatic test_timeout();
    start();
    fill_random(13);
    make_exp(12);
    send(0, 100, 0);
    idle(18);
    checks++;
    if (ferr !== 1) begin
      errors++;
      $display("FAIL timeout_pulses got %0d want 1", ferr);
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL timeout_syms got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL timeout_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    start();
    fill_random(RS_N);
    make_exp(RS_N);
    send(0, RS_TOTAL_BITS, 0);
    idle(3);
    cw += 1;
    checks++;
    if (got.size() != exp.size() || ferr !== 0) begin
      errors++;
      $display("FAIL recover_count got %0d syms %0d errs want %0d syms 0 errs", got.size(), ferr, exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL recover_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask
  task automatic test_late_bit();
    start();
    fill_random(RS_N);
    make_exp(RS_N);
    send(0, 203, 0);
    idle(15);
    send(203, RS_TOTAL_BITS, 0);
    idle(3);
    cw += 1;
    checks++;
    if (ferr !== 0) begin
      errors++;
      $display("FAIL late_frame_error got %0d pulses want 0", ferr);
    end
    checks++;
    if (got.size() != exp.size()) begin
      errors++;
      $display("FAIL late_count got %0d want %0d", got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL late_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask
  task automatic test_async_reset();
    start();
    fill_random(RS_N);
    data[19] = 8'hA5;
    send(0, 20 * 8 + 3, 0);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.symbol_out, bus.symbol_out_valid, bus.symbol_sop, bus.symbol_eop, bus.symbol_is_parity,
         bus.symbol_index, bus.frame_error, bus.codeword_count} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs out %h cnt %0d want 0", bus.symbol_out, bus.codeword_count);
    end
    @(posedge clk);
    #3 rstn = 1'b1;
    cw = 0;
    checks++;
    if (ferr !== 0) begin
      errors++;
      $display("FAIL async_reset_frame_error got %0d want 0", ferr);
    end
    start();
    fill_random(RS_N);
    make_exp(RS_N);
    send(0, RS_TOTAL_BITS, 0);
    idle(3);
    cw += 1;
    checks++;
    if (got.size() != exp.size() || ferr !== 0) begin
      errors++;
      $display("FAIL post_reset_count got %0d syms %0d errs want %0d syms 0 errs", got.size(), ferr, exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL post_reset_sym%0d got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_full_codeword();
    test_back_to_back();
    test_gaps();
    test_timeout();
    test_late_bit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
